// File: rtl/load_use_hazard_ctrl_pkg.sv
// Shared widths, tuning constants, FSM encoding and age-queue entry type for the
// load-use interlock. The forwarding unit takes REG_ADDR_W from here too.
package load_use_hazard_ctrl_pkg;

   localparam int REG_ADDR_W  = 4;
   localparam int OP3_ADDR_W  = 3;
   localparam int NUM_REGS    = 16;
   localparam int LOAD_LAT    = 2;
   localparam int MAX_STALL   = 15;
   localparam int STALL_CNT_W = 4;
   localparam int PERF_CNT_W  = 16;

   typedef enum logic [1:0] {
      LUH_RUN   = 2'd0,
      LUH_STALL = 2'd1,
      LUH_ERR   = 2'd2
   } luh_state_e;

   typedef struct packed {
      logic                  vld;
      logic [REG_ADDR_W-1:0] addr;
   } age_ent_t;

   function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] addr);
      return NUM_REGS'(1) << addr;
   endfunction

endpackage

// File: rtl/load_use_hazard_ctrl_scoreboard.sv
// Pending-load bit per architectural register; one-cycle update, set beats clear.
// No backpressure: set/clear/clear-all are accepted every cycle.
module luh_scoreboard
   import load_use_hazard_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic                  clr_all,
   output logic [NUM_REGS-1:0]   pending
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Set is applied last so a load re-issuing on its predecessor's WB cycle stays pending.
   always_comb begin
      pending_d = pending_q;
      if (clr_all) begin
         pending_d = '0;
      end
      if (clr_en) begin
         pending_d = pending_d & ~reg_bit(clr_addr);
      end
      if (set_en) begin
         pending_d = pending_d | reg_bit(set_addr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/load_use_hazard_ctrl.sv
// Load-use interlock: zero-latency stall/bubble on collision with an in-flight load; the
// stall is the backpressure it applies to IF/ID. Optional LUH_PERF_CNT_EN adds perf_stall_cnt.
module load_use_hazard_ctrl
   import load_use_hazard_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_op1_addr,
   input  logic                  id_op1_use,
   input  logic [REG_ADDR_W-1:0] id_op2_addr,
   input  logic                  id_op2_use,
   input  logic [OP3_ADDR_W-1:0] id_op3_addr,
   input  logic                  id_op3_use,
   input  logic [REG_ADDR_W-1:0] id_dst_addr,
   input  logic                  id_reg_wr_en,
   input  logic                  id_load,
   input  logic                  wb_reg_wr_en,
   input  logic [REG_ADDR_W-1:0] wb_dst_addr,
   input  logic                  wb_load,
   input  logic                  flush,
   output logic                  stall_ifid,
   output logic                  bubble_ex,
   output logic [NUM_REGS-1:0]   pending_mask,
`ifdef LUH_PERF_CNT_EN
   output logic [PERF_CNT_W-1:0] perf_stall_cnt,
`endif
   output logic                  hazard_err
);

   localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(MAX_STALL - 1);
   localparam logic [STALL_CNT_W-1:0] STALL_SAT  = '1;

   luh_state_e             state_q, state_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   err_q, err_d;
   age_ent_t               age_q [LOAD_LAT];
   age_ent_t               age_d [LOAD_LAT];
   age_ent_t               due_q, due_d;

   logic                   wb_fwd;
   logic [NUM_REGS-1:0]    wb_mask;
   logic [NUM_REGS-1:0]    live_mask;
   logic                   src_hit;
   logic                   hit;
   logic                   issue;
   logic                   lost_wb;
   logic                   clr_all;

   // A load writing back this cycle is forwarded, so its register no longer blocks ID.
   always_comb begin
      wb_fwd    = wb_reg_wr_en & wb_load;
      wb_mask   = wb_fwd ? reg_bit(wb_dst_addr) : '0;
      live_mask = pending_mask & ~wb_mask;
      src_hit   = (id_op1_use   & live_mask[id_op1_addr])
                | (id_op2_use   & live_mask[id_op2_addr])
                | (id_op3_use   & live_mask[REG_ADDR_W'(id_op3_addr)])
                | (id_reg_wr_en & live_mask[id_dst_addr]);
      hit       = id_valid & ~flush & src_hit;
      issue     = id_valid & id_load & id_reg_wr_en & ~hit & ~flush;
   end

   assign stall_ifid = hit & (state_q != LUH_ERR);
   assign bubble_ex  = stall_ifid;
   assign hazard_err = err_q;

   luh_scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue),
      .set_addr (id_dst_addr),
      .clr_en   (wb_fwd),
      .clr_addr (wb_dst_addr),
      .clr_all  (clr_all),
      .pending  (pending_mask)
   );

   // Each issued load walks the queue; after the last slot it sits in due_q during the
   // cycle its writeback must arrive, and a miss there means the WB was lost.
   always_comb begin
      age_d[0] = '{vld: issue, addr: id_dst_addr};
      for (int i = 1; i < LOAD_LAT; i++) begin
         age_d[i] = age_q[i-1];
      end
      due_d   = age_q[LOAD_LAT-1];
      lost_wb = due_q.vld & ~(wb_fwd & (wb_dst_addr == due_q.addr));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LOAD_LAT; i++) begin
            age_q[i] <= '0;
         end
         due_q <= '0;
      end else begin
         for (int i = 0; i < LOAD_LAT; i++) begin
            age_q[i] <= age_d[i];
         end
         due_q <= due_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      clr_all     = 1'b0;
      err_d       = err_q | lost_wb;
      case (state_q)
         LUH_RUN: begin
            stall_cnt_d = '0;
            if (hit) begin
               state_d = LUH_STALL;
            end
         end
         LUH_STALL: begin
            if (!hit) begin
               state_d     = LUH_RUN;
               stall_cnt_d = '0;
            end else if (stall_cnt_q == STALL_LAST) begin
               // Stall has run past its limit: drop every pending bit to break the deadlock.
               state_d     = LUH_ERR;
               stall_cnt_d = stall_cnt_q + 1'b1;
               clr_all     = 1'b1;
               err_d       = 1'b1;
            end else if (stall_cnt_q != STALL_SAT) begin
               stall_cnt_d = stall_cnt_q + 1'b1;
            end
         end
         LUH_ERR: begin
            state_d     = LUH_RUN;
            stall_cnt_d = '0;
         end
         default: begin
            state_d     = LUH_RUN;
            stall_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LUH_RUN;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

`ifdef LUH_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q + PERF_CNT_W'(stall_ifid);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_q <= '0;
      end else begin
         perf_q <= perf_d;
      end
   end

   assign perf_stall_cnt = perf_q;
`endif

endmodule
